// File: rtl/modport_conv.sv
// ----------------------------------------------------------------------------
// modport_conv
//   Streaming convolution multiply-accumulate engine. Feature words (a) and
//   weight words (b) arrive in lockstep, already ordered and zero-padded by the
//   producer. The engine performs K*K*CI MACs per output word and emits one
//   tagged result per output pixel/channel. It holds no feature-map storage:
//   just one accumulator, the loop counters and a three-state control FSM.
//
//   Loop order: y (outer), x, output channel; inside each window ky, kx,
//   input channel (innermost).
//
// Ports
//   clk               rising-edge clock
//   arst_n            asynchronous reset, ACTIVE-HIGH despite its name
//   conv_kernel_mode  0:1x1 1:3x3 2:5x5 3:7x7, sampled at start
//   conv_stride_mode  0:S=1 1:S=2 2:S=4 3:S=1, sampled at start
//   start             begin a job when idle (ignored while running)
//   running           job in progress
//   a_input/a_valid/a_ready   feature word stream
//   b_input/b_valid/b_ready   weight word stream
//   output_data       saturated, scaled result
//   output_valid      one-cycle result strobe (no backpressure)
//   output_x/_y/_ch   output-grid coordinates of output_data
// ----------------------------------------------------------------------------
module modport_conv #(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 8,
    parameter int FEATURE_MAP_HEIGHT = 8,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 4,
    parameter int FRAC_BITS          = 0
) (
    input  logic                                   clk,
    input  logic                                   arst_n,
    input  logic [1:0]                             conv_kernel_mode,
    input  logic [1:0]                             conv_stride_mode,
    input  logic                                   start,
    output logic                                   running,
    input  logic signed [DATA_WIDTH-1:0]           a_input,
    input  logic                                   a_valid,
    output logic                                   a_ready,
    input  logic signed [DATA_WIDTH-1:0]           b_input,
    input  logic                                   b_valid,
    output logic                                   b_ready,
    output logic signed [DATA_WIDTH-1:0]           output_data,
    output logic                                   output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  output_ch
);

    localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW    = $clog2(OUTPUT_NB_CHANNELS);
    localparam int IW    = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
    localparam int PW    = 2 * DATA_WIDTH;
    // Worst case is a 7x7 window over every input channel, so this width
    // can never overflow.
    localparam int ACC_W = PW + $clog2(49 * INPUT_NB_CHANNELS);

    localparam logic [IW-1:0] ICH_LAST = IW'(INPUT_NB_CHANNELS - 1);
    localparam logic [CW-1:0] OCH_LAST = CW'(OUTPUT_NB_CHANNELS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]              kernel_q;
    logic [1:0]              stride_q;
    logic [IW-1:0]           ich_q;
    logic [2:0]              kx_q, ky_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [CW-1:0]           och_q;
    logic signed [ACC_W-1:0] acc_q;

    logic [2:0]              k_last;
    logic [XW-1:0]           ow_last;
    logic [YW-1:0]           oh_last;
    logic                    mac_fire;
    logic                    win_last;
    logic                    out_last;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [DATA_WIDTH-1:0] sat_out;

    // K = 2*mode+1, so the last kernel index K-1 is simply mode*2.
    assign k_last = {kernel_q, 1'b0};

    // Output grid extent is ceil(dim/S); keep the last index per stride.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        ow_last = XW'(FEATURE_MAP_WIDTH - 1);
        oh_last = YW'(FEATURE_MAP_HEIGHT - 1);
        unique case (stride_q)
            2'd1: begin
                ow_last = XW'((FEATURE_MAP_WIDTH + 1) / 2 - 1);
                oh_last = YW'((FEATURE_MAP_HEIGHT + 1) / 2 - 1);
            end
            2'd2: begin
                ow_last = XW'((FEATURE_MAP_WIDTH + 3) / 4 - 1);
                oh_last = YW'((FEATURE_MAP_HEIGHT + 3) / 4 - 1);
            end
            default: ;
        endcase
    end

    // Both sides transfer together or not at all.
    assign mac_fire = (state_q == MAC) && a_valid && b_valid;
    assign a_ready  = mac_fire;
    assign b_ready  = mac_fire;

    assign win_last = mac_fire && (ich_q == ICH_LAST) && (kx_q == k_last) && (ky_q == k_last);
    assign out_last = (och_q == OCH_LAST) && (x_q == ow_last) && (y_q == oh_last);

    // running falls in the same cycle as the final output strobe.
    assign running = (state_q == MAC) || ((state_q == EMIT) && !out_last);

    assign prod    = a_input * b_input;
    assign acc_sum = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign shifted = acc_sum >>> FRAC_BITS;

    always_comb begin
        sat_out = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat_out = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_out = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Control FSM: state register.
    always_ff @(posedge clk or posedge arst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = MAC;
            MAC:     if (win_last) state_d = EMIT;
            EMIT:    state_d = out_last ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: accumulator, loop counters, registered result.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            kernel_q     <= '0;
            stride_q     <= '0;
            ich_q        <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            och_q        <= '0;
            acc_q        <= '0;
            output_data  <= '0;
            output_valid <= 1'b0;
            output_x     <= '0;
            output_y     <= '0;
            output_ch    <= '0;
        end else begin
            output_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        kernel_q <= conv_kernel_mode;
                        stride_q <= conv_stride_mode;
                        ich_q    <= '0;
                        kx_q     <= '0;
                        ky_q     <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        och_q    <= '0;
                        acc_q    <= '0;
                    end
                end
                MAC: begin
                    if (win_last) begin
                        // Final MAC folds straight into the result; the
                        // accumulator restarts clean for the next window.
                        acc_q        <= '0;
                        ich_q        <= '0;
                        kx_q         <= '0;
                        ky_q         <= '0;
                        output_data  <= sat_out;
                        output_valid <= 1'b1;
                        output_x     <= x_q;
                        output_y     <= y_q;
                        output_ch    <= och_q;
                    end else if (mac_fire) begin
                        acc_q <= acc_sum;
                        if (ich_q == ICH_LAST) begin
                            ich_q <= '0;
                            if (kx_q == k_last) begin
                                kx_q <= '0;
                                ky_q <= ky_q + 3'd1;
                            end else begin
                                kx_q <= kx_q + 3'd1;
                            end
                        end else begin
                            ich_q <= ich_q + IW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (!out_last) begin
                        if (och_q == OCH_LAST) begin
                            och_q <= '0;
                            if (x_q == ow_last) begin
                                x_q <= '0;
                                y_q <= y_q + YW'(1);
                            end else begin
                                x_q <= x_q + XW'(1);
                            end
                        end else begin
                            och_q <= och_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modport_conv.sv
// ----------------------------------------------------------------------------
// tb_modport_conv
//   Drives modport_conv with pre-ordered a/b streams and compares every output
//   strobe against a reference computed directly from the convolution rules:
//   output j sums the products of its K*K*CI consecutive pairs, then shifts
//   and saturates; its coordinates follow from j in y, x, ch order.
//   A second instance built with FRAC_BITS=4 shares the stimulus and is only
//   checked by the scaling test.
// ----------------------------------------------------------------------------
module tb_modport_conv;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CI = 2;
    localparam int CO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 arst_n;
    logic [1:0]           conv_kernel_mode;
    logic [1:0]           conv_stride_mode;
    logic                 start;
    logic signed [DW-1:0] a_input, b_input;
    logic                 a_valid, b_valid;

    logic                 running, a_ready, b_ready, output_valid;
    logic signed [DW-1:0] output_data;
    logic [2:0]           output_x, output_y;
    logic [1:0]           output_ch;

    logic                 f_running, f_a_ready, f_b_ready, f_output_valid;
    logic signed [DW-1:0] f_output_data;
    logic [2:0]           f_output_x, f_output_y;
    logic [1:0]           f_output_ch;

    int total = 0;
    int bad   = 0;

    modport_conv dut (
        .clk(clk), .arst_n(arst_n),
        .conv_kernel_mode(conv_kernel_mode), .conv_stride_mode(conv_stride_mode),
        .start(start), .running(running),
        .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
        .output_data(output_data), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
    );

    modport_conv #(.FRAC_BITS(4)) dut_f (
        .clk(clk), .arst_n(arst_n),
        .conv_kernel_mode(conv_kernel_mode), .conv_stride_mode(conv_stride_mode),
        .start(start), .running(f_running),
        .a_input(a_input), .a_valid(a_valid), .a_ready(f_a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(f_b_ready),
        .output_data(f_output_data), .output_valid(f_output_valid),
        .output_x(f_output_x), .output_y(f_output_y), .output_ch(f_output_ch)
    );

    // Which instance the job runner observes.
    logic                 sel_f = 1'b0;
    wire                  m_valid   = sel_f ? f_output_valid : output_valid;
    wire signed [DW-1:0]  m_data    = sel_f ? f_output_data  : output_data;
    wire [2:0]            m_x       = sel_f ? f_output_x     : output_x;
    wire [2:0]            m_y       = sel_f ? f_output_y     : output_y;
    wire [1:0]            m_ch      = sel_f ? f_output_ch    : output_ch;
    wire                  m_running = sel_f ? f_running      : running;
    wire                  m_a_ready = sel_f ? f_a_ready      : a_ready;
    wire                  m_b_ready = sel_f ? f_b_ready      : b_ready;

    function automatic int sat_ref(input longint v, input int frac);
        longint s;
        s = v >>> frac;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    // Runs one complete job and checks every strobe.
    // dmode 0: constant a/b values; dmode 1: random words in [-40,40].
    task automatic run_job(input int km, input int sm, input int dmode,
                           input int av, input int bv, input bit rnd_valid,
                           input bit use_f, input bit pulse_start, input string tag);
        int k, s, ow, oh, nout, win, npairs, budget;
        int a_arr[], b_arr[], exp_arr[];
        int i, j, cyc, dcyc;
        bit hs;
        longint acc;
        logic signed [DW-1:0] ed;
        logic [2:0] ex, ey;
        logic [1:0] ec;

        k      = 2 * km + 1;
        s      = (sm == 1) ? 2 : (sm == 2) ? 4 : 1;
        ow     = (W + s - 1) / s;
        oh     = (H + s - 1) / s;
        nout   = ow * oh * CO;
        win    = k * k * CI;
        npairs = nout * win;
        budget = npairs * 12 + 400;

        a_arr = new[npairs];
        b_arr = new[npairs];
        exp_arr = new[nout];
        for (int p = 0; p < npairs; p++) begin
            if (dmode == 1) begin
                a_arr[p] = int'($urandom_range(80)) - 40;
                b_arr[p] = int'($urandom_range(80)) - 40;
            end else begin
                a_arr[p] = av;
                b_arr[p] = bv;
            end
        end
        for (int o = 0; o < nout; o++) begin
            acc = 0;
            for (int p = o * win; p < (o + 1) * win; p++)
                acc += longint'(a_arr[p]) * longint'(b_arr[p]);
            exp_arr[o] = sat_ref(acc, use_f ? 4 : 0);
        end

        sel_f = use_f;
        @(negedge clk);
        conv_kernel_mode = 2'(km);
        conv_stride_mode = 2'(sm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (m_running !== 1'b1) begin
            bad++;
            $display("FAIL %s running_after_start: got %b want 1", tag, m_running);
        end

        fork
            begin : driver
                i = 0;
                dcyc = 0;
                while (i < npairs && dcyc < budget) begin
                    a_valid = rnd_valid ? 1'($urandom_range(1)) : 1'b1;
                    b_valid = rnd_valid ? 1'($urandom_range(1)) : 1'b1;
                    a_input = DW'(a_arr[i]);
                    b_input = DW'(b_arr[i]);
                    start   = (pulse_start && dcyc == 20) ? 1'b1 : 1'b0;
                    #1;
                    hs = m_a_ready && m_b_ready;
                    if (a_valid !== b_valid) begin
                        total++;
                        if (m_a_ready !== 1'b0 || m_b_ready !== 1'b0) begin
                            bad++;
                            $display("FAIL %s one_sided_transfer: a_ready=%b b_ready=%b want 0",
                                     tag, m_a_ready, m_b_ready);
                        end
                    end
                    @(negedge clk);
                    dcyc++;
                    if (hs) i++;
                end
                a_valid = 1'b0;
                b_valid = 1'b0;
                start   = 1'b0;
                total++;
                if (i !== npairs) begin
                    bad++;
                    $display("FAIL %s feed_timeout: pairs=%0d want %0d", tag, i, npairs);
                end
            end
            begin : monitor
                j = 0;
                cyc = 0;
                while (j < nout && cyc < budget) begin
                    @(negedge clk);
                    cyc++;
                    if (m_valid === 1'b1) begin
                        ed = DW'(exp_arr[j]);
                        ec = 2'(j % CO);
                        ex = 3'((j / CO) % ow);
                        ey = 3'(j / (CO * ow));
                        total++;
                        if (m_data !== ed) begin
                            bad++;
                            $display("FAIL %s data[%0d]: got %0d want %0d", tag, j, m_data, ed);
                        end
                        total++;
                        if (m_x !== ex || m_y !== ey || m_ch !== ec) begin
                            bad++;
                            $display("FAIL %s coords[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                     tag, j, m_x, m_y, m_ch, ex, ey, ec);
                        end
                        total++;
                        if (m_running !== ((j == nout - 1) ? 1'b0 : 1'b1)) begin
                            bad++;
                            $display("FAIL %s running_at_strobe[%0d]: got %b want %b",
                                     tag, j, m_running, (j == nout - 1) ? 1'b0 : 1'b1);
                        end
                        j++;
                    end
                end
                total++;
                if (j !== nout) begin
                    bad++;
                    $display("FAIL %s strobe_timeout: strobes=%0d want %0d", tag, j, nout);
                end
            end
        join

        repeat (3) begin
            @(negedge clk);
            total++;
            if (m_valid !== 1'b0 || m_running !== 1'b0) begin
                bad++;
                $display("FAIL %s idle_after_job: valid=%b running=%b want 0 0",
                         tag, m_valid, m_running);
            end
        end
        sel_f = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (running !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || output_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: running=%b a_ready=%b b_ready=%b valid=%b want 0",
                     running, a_ready, b_ready, output_valid);
        end
        total++;
        if (output_data !== 16'sd0 || output_x !== 3'd0 || output_y !== 3'd0 || output_ch !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: data=%0d x=%0d y=%0d ch=%0d want 0",
                     output_data, output_x, output_y, output_ch);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        start = 1'b0;
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: running=%b want 0", running);
        end
    endtask

    task automatic test_k1_s1();
        run_job(0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0, "k1_s1_ones");
    endtask

    task automatic test_k3_s2();
        run_job(1, 1, 0, 3, -2, 1'b0, 1'b0, 1'b0, "k3_s2_const");
    endtask

    task automatic test_saturation();
        run_job(3, 2, 0, 32767, 32767, 1'b0, 1'b0, 1'b0, "sat_pos");
        run_job(3, 2, 0, -32768, 32767, 1'b0, 1'b0, 1'b0, "sat_neg");
    endtask

    task automatic test_random_valid();
        run_job(0, 0, 0, 1, 1, 1'b1, 1'b0, 1'b0, "rnd_valid");
    endtask

    task automatic test_random_data();
        run_job(2, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0, "rnd_k5_s2");
        run_job(1, 2, 1, 0, 0, 1'b0, 1'b0, 1'b0, "rnd_k3_s4");
        run_job(0, 3, 1, 0, 0, 1'b1, 1'b0, 1'b0, "rnd_k1_smode3");
    endtask

    task automatic test_start_ignored();
        run_job(0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b1, "start_mid_job");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        conv_kernel_mode = 2'd0;
        conv_stride_mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_input = 16'sd1;
        b_input = 16'sd1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_running: got %b want 1", running);
        end
        #2 arst_n = 1'b1;
        #1;
        total++;
        if (running !== 1'b0 || a_ready !== 1'b0 || output_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_async_ctrl: running=%b a_ready=%b valid=%b want 0",
                     running, a_ready, output_valid);
        end
        total++;
        if (output_data !== 16'sd0 || output_x !== 3'd0 || output_ch !== 2'd0) begin
            bad++;
            $display("FAIL abort_async_data: data=%0d x=%0d ch=%0d want 0",
                     output_data, output_x, output_ch);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        run_job(0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0, "restart_after_abort");
    endtask

    task automatic test_frac();
        run_job(0, 2, 0, 16, 16, 1'b0, 1'b1, 1'b0, "frac4");
    endtask

    initial begin
        arst_n = 1'b1;
        conv_kernel_mode = 2'd0;
        conv_stride_mode = 2'd0;
        start = 1'b0;
        a_input = '0;
        b_input = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;

        test_reset();
        test_k1_s1();
        test_k3_s2();
        test_saturation();
        test_random_valid();
        test_random_data();
        test_start_ignored();
        test_async_reset();
        test_frac();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
